multicycle_ctrl: RTL

- Multi-cycle sequencer for the 16-bit datapath (6-bit PC, 16x16 register file, 4-bit-addressed data memory, 3-bit-op ALU).
- Replaces the single-cycle decoder: steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath enable.
- Talks to instruction and data memory over req/ack handshakes, so memories may take wait states.

---
 rtl/mctrl_pkg.sv | 35 +++
 rtl/multicycle_ctrl_if.sv | 37 +++
 rtl/mctrl_wait_timer.sv | 39 +++
 rtl/multicycle_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mctrl_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package mctrl_pkg;

  localparam int unsigned OPW    = 4;
  localparam int unsigned ALUOPW = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    FAULT  = 3'd7
  } state_e;

  localparam logic [OPW-1:0]    OP_ADDI = 4'h8;
  localparam logic [OPW-1:0]    OP_LW   = 4'h9;
  localparam logic [OPW-1:0]    OP_SW   = 4'hA;
  localparam logic [OPW-1:0]    OP_BNE  = 4'hB;
  localparam logic [OPW-1:0]    OP_HALT = 4'hF;
  localparam logic [ALUOPW-1:0] ALU_ADD = 3'b000;

  // Opcodes 0x0-0x7 are register-register ALU operations.
  function automatic logic is_rtype(input logic [OPW-1:0] op);
    return ~op[OPW-1];
  endfunction

  // 0xC-0xE are reserved and execute as no-ops.
  function automatic logic is_nop(input logic [OPW-1:0] op);
    return (op[OPW-1 -: 2] == 2'b11) && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the sequencer (master) and the datapath/memories (slave).
interface multicycle_ctrl_if;
  import mctrl_pkg::*;

  logic              start;
  logic [OPW-1:0]    opcode;
  logic              eq;
  logic              imem_req;
  logic              imem_ack;
  logic              dmem_req;
  logic              dmem_ack;
  logic              dmem_we;
  logic              ir_we;
  logic              pc_we;
  logic              pc_src;
  logic              reg_we;
  logic              reg_dst;
  logic              alu_src;
  logic [ALUOPW-1:0] alu_op;
  logic              mem_to_reg;
  logic              busy;
  logic              halted;
  logic              fault;

  modport master (
    input  start, opcode, eq, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we, reg_dst,
           alu_src, alu_op, mem_to_reg, busy, halted, fault
  );

  modport slave (
    output start, opcode, eq, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we, reg_dst,
           alu_src, alu_op, mem_to_reg, busy, halted, fault
  );

endinterface

// File: rtl/mctrl_wait_timer.sv
// Counts stalled request cycles and flags the cycle whose stall would reach WAIT_MAX.
module mctrl_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic req_i,
  input  logic ack_i,
  output logic timeout_c_o
);

  localparam int unsigned CNTW = 8;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            stall_c;

  assign stall_c     = req_i & ~ack_i;
  // An ack in the limit cycle suppresses the stall, so the access completes instead.
  assign timeout_c_o = stall_c && (cnt_q == CNTW'(WAIT_MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (stall_c) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack memory handshakes.
// Define MCTRL_PERF_EN to add the cyc_cnt/ret_cnt performance counters.
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
`ifdef MCTRL_PERF_EN
  ,
  output logic [31:0]        cyc_cnt,
  output logic [31:0]        ret_cnt
`endif
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic           wait_req_c;
  logic           wait_ack_c;
  logic           wait_clr_c;
  logic           timeout_c;
  logic           busy_c;

  // Stall tracking depends only on the registered state, keeping it off the next-state path.
  assign wait_req_c = (state_q == FETCH) || (state_q == MEM);
  assign wait_ack_c = ((state_q == FETCH) && bus.imem_ack) || ((state_q == MEM) && bus.dmem_ack);
  assign wait_clr_c = (state_d != state_q) && ((state_d == FETCH) || (state_d == MEM));
  assign busy_c     = !(state_q inside {IDLE, HALT, FAULT});

  mctrl_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (wait_clr_c),
    .req_i       (wait_req_c),
    .ack_i       (wait_ack_c),
    .timeout_c_o (timeout_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    bus.imem_req   = 1'b0;
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.pc_src     = 1'b0;
    bus.reg_we     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.alu_src    = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.mem_to_reg = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = FETCH;
      end
      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
          op_d      = bus.opcode;
          state_d   = DECODE;
        end else if (timeout_c) begin
          state_d = FAULT;
        end
      end
      DECODE: begin
        if (op_q == OP_HALT)    state_d = HALT;
        else if (is_nop(op_q))  state_d = FETCH;
        else                    state_d = EXEC;
      end
      EXEC: begin
        if (is_rtype(op_q)) begin
          bus.alu_op = op_q[ALUOPW-1:0];
          state_d    = WB;
        end else if (op_q == OP_BNE) begin
          bus.pc_we  = ~bus.eq;
          bus.pc_src = ~bus.eq;
          state_d    = FETCH;
        end else begin
          bus.alu_src = 1'b1;
          state_d     = (op_q == OP_ADDI) ? WB : MEM;
        end
      end
      MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (op_q == OP_SW);
        if (bus.dmem_ack) begin
          state_d = (op_q == OP_LW) ? WB : FETCH;
        end else if (timeout_c) begin
          state_d = FAULT;
        end
      end
      WB: begin
        bus.reg_we     = 1'b1;
        bus.mem_to_reg = (op_q == OP_LW);
        bus.reg_dst    = is_rtype(op_q);
        state_d        = FETCH;
      end
      HALT: begin
        if (bus.start) state_d = FETCH;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    bus.busy   = busy_c;
    bus.halted = (state_q == HALT);
    bus.fault  = (state_q == FAULT);
  end

`ifdef MCTRL_PERF_EN
  logic [31:0] cyc_q, ret_q;
  logic        ret_c;

  // A retirement is any return to FETCH from an instruction's final state.
  assign ret_c = (state_d == FETCH) && (state_q inside {DECODE, EXEC, MEM, WB});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (busy_c) cyc_q <= cyc_q + 32'd1;
      if (ret_c)  ret_q <= ret_q + 32'd1;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`endif

endmodule
